// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch stage and imem.
// Rev 1.0
`default_nettype none

interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_done);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_done);
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: 16-bit fetch stage (FETCH/WAIT/HOLD/HALTED) feeding an IF/ID register. Rev 1.0
// Macro FETCH_PERF_CNT_EN enables a saturating accepted-fetch counter on fetch_count.
`default_nettype none

module fetch_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_in,
  input  logic         redirect_valid,
  input  logic [15:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [15:0]  if_instr,
  output logic [15:0]  if_pc_plus2,
  output logic         if_valid,
  output logic         halted,
  output logic         err,
  output logic [15:0]  fetch_count
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pending;
  logic        discard;
  logic        accept;
  logic [15:0] acc_instr;
  logic        acc_halt;

  // Request is suppressed while reset is held so the bus stays quiet.
  assign imem.imem_req  = rst && (state == FETCH) && !stall_in && !redirect_valid;
  assign imem.imem_addr = pc;
  assign err            = imem.imem_req && pc[0];

  always_comb begin
    accept    = 1'b0;
    acc_instr = imem.imem_rdata;
    if (!redirect_valid) begin
      case (state)
        FETCH:   accept = !stall_in && imem.imem_done;
        WAIT:    accept = imem.imem_done && !discard && !stall_in;
        HOLD: begin
          accept    = !stall_in;
          acc_instr = pending;
        end
        default: accept = 1'b0;
      endcase
    end
    acc_halt = (acc_instr[15:11] == 5'b00000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= 16'h0000;
      pending     <= 16'h0000;
      discard     <= 1'b0;
      if_instr    <= NOP;
      if_pc_plus2 <= 16'h0000;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      pending  <= 16'h0000;
      if_instr <= NOP;
      if_valid <= 1'b0;
      halted   <= 1'b0;
      // An access still in flight must have its eventual response dropped.
      if (state == WAIT && !imem.imem_done) begin
        discard <= 1'b1;
        state   <= WAIT;
      end else begin
        discard <= 1'b0;
        state   <= FETCH;
      end
    end else if (accept) begin
      if_instr    <= acc_instr;
      if_pc_plus2 <= pc + 16'd2;
      if_valid    <= 1'b1;
      pc          <= pc + 16'd2;
      if (acc_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (!stall_in && !imem.imem_done) state <= WAIT;
        end
        WAIT: begin
          if (imem.imem_done) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= FETCH;
            end else begin
              pending <= imem.imem_rdata;
              state   <= HOLD;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'h0000;
    end else if (accept && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a flag-based fetch model.
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] if_instr, if_pc_plus2, fetch_count;
  logic        if_valid, halted, err;
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem.master),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .if_valid       (if_valid),
    .halted         (halted),
    .err            (err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [15:0] rp,
                       input logic dn, input logic [15:0] rd);
    stall_in            = st;
    redirect_valid      = rv;
    redirect_pc         = rp;
    imem.imem_done      = dn;
    imem.imem_rdata     = rd;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick;
    tick;
    rst = 1'b1;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a[5:1] == 5'd0) return {5'b00000, a[10:0]};
    return (a ^ 16'hA5C3) | 16'h0800;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4700);
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (if_instr !== 16'h0800) begin n_fail++; $display("FAIL rst_instr: got %h want 0800", if_instr); end
    n_checks++; if (if_pc_plus2 !== 16'h0000) begin n_fail++; $display("FAIL rst_pcp2: got %h want 0000", if_pc_plus2); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_checks++; if (imem.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", imem.imem_addr); end
    n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL rst_count: got %h want 0000", fetch_count); end
    tick;
    rst = 1'b1;
    // Late completion from an abandoned access while stalled must not be captured.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4800);
    tick;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL late_done: valid got %b want 0", if_valid); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
    n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL b2b_req0: req %b addr %h want 1 0000", imem.imem_req, imem.imem_addr); end
    tick;
    n_checks++; if (if_instr !== 16'h4000 || if_pc_plus2 !== 16'h0002 || if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_if0: %h %h %b want 4000 0002 1", if_instr, if_pc_plus2, if_valid); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4100);
    n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0002) begin n_fail++; $display("FAIL b2b_req1: req %b addr %h want 1 0002", imem.imem_req, imem.imem_addr); end
    tick;
    n_checks++; if (if_instr !== 16'h4100 || if_pc_plus2 !== 16'h0004) begin n_fail++; $display("FAIL b2b_if1: %h %h want 4100 0004", if_instr, if_pc_plus2); end
  endtask

  task automatic test_late_hold;
    do_reset;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_req%0d: got %b want 0", k, imem.imem_req); end
      tick;
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4200);
    tick;
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick;
    n_checks++; if (if_instr !== 16'h0800 || if_valid !== 1'b0) begin n_fail++; $display("FAIL hold_keep: %h %b want 0800 0", if_instr, if_valid); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem.imem_req); end
    tick;
    n_checks++; if (if_instr !== 16'h4200 || if_pc_plus2 !== 16'h0002 || imem.imem_addr !== 16'h0002) begin n_fail++; $display("FAIL hold_rel: %h %h %h want 4200 0002 0002", if_instr, if_pc_plus2, imem.imem_addr); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
    tick;
    n_checks++; if (if_instr !== 16'h0800 || if_valid !== 1'b0 || imem.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rdw_a: %h %b %h want 0800 0 0040", if_instr, if_valid, imem.imem_addr); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4300);
    n_checks++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_req: got %b want 0", imem.imem_req); end
    tick;
    n_checks++; if (if_instr !== 16'h0800 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_drop: %h %b want 0800 0", if_instr, if_valid); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4400);
    n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rdw_new: %b %h want 1 0040", imem.imem_req, imem.imem_addr); end
    tick;
    n_checks++; if (if_instr !== 16'h4400 || if_pc_plus2 !== 16'h0042) begin n_fail++; $display("FAIL rdw_if: %h %h want 4400 0042", if_instr, if_pc_plus2); end
  endtask

  task automatic test_halt;
    do_reset;
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    tick;
    n_checks++; if (halted !== 1'b1 || if_instr !== 16'h0000 || if_valid !== 1'b1 || if_pc_plus2 !== 16'h0012) begin n_fail++; $display("FAIL halt_set: %b %h %b %h want 1 0000 1 0012", halted, if_instr, if_valid, if_pc_plus2); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
      n_checks++; if (imem.imem_req !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold%0d: req %b halted %b want 0 1", k, imem.imem_req, halted); end
      tick;
    end
    drive(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000);
    tick;
    n_checks++; if (halted !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_clr: %b %b want 0 0", halted, if_valid); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4500);
    n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0020) begin n_fail++; $display("FAIL halt_refetch: %b %h want 1 0020", imem.imem_req, imem.imem_addr); end
    tick;
    n_checks++; if (if_instr !== 16'h4500) begin n_fail++; $display("FAIL halt_if: got %h want 4500", if_instr); end
  endtask

  task automatic test_misalign_count;
    logic [15:0] exp_cnt;
    do_reset;
    drive(1'b0, 1'b1, 16'h0021, 1'b0, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4600);
    n_checks++; if (err !== 1'b1 || imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0021) begin n_fail++; $display("FAIL mis_err: err %b req %b addr %h want 1 1 0021", err, imem.imem_req, imem.imem_addr); end
    tick;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4600);
      tick;
    end
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    n_checks++; if (fetch_count !== exp_cnt) begin n_fail++; $display("FAIL count: got %0d want %0d", fetch_count, exp_cnt); end
    n_checks++; if (if_pc_plus2 !== 16'h0027) begin n_fail++; $display("FAIL mis_pcp2: got %h want 0027", if_pc_plus2); end
  endtask

  task automatic test_random;
    logic [15:0] m_pc, m_ifi, m_ifpc, m_cnt, m_pend, saddr, got, rp, rd;
    logic        m_ifv, m_halt, m_out, m_disc, m_hp, exp_req, gotv, st, rv, dn;
    int          busy, lat, r;
    do_reset;
    m_pc = 16'h0000; m_ifi = 16'h0800; m_ifpc = 16'h0000; m_cnt = 16'h0000; m_pend = 16'h0000;
    m_ifv = 1'b0; m_halt = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_hp = 1'b0; busy = 0; saddr = 16'h0000;
    for (int i = 0; i < 800; i++) begin
      st = ($urandom % 4) == 0;
      rv = ($urandom % 12) == 0;
      r  = $urandom % 8;
      rp = (r == 0) ? 16'hFFFC : (r == 1) ? (16'($urandom) | 16'h0001) : (16'($urandom) & 16'hFFFE);
      exp_req = !m_halt && !m_out && !m_hp && !st && !rv;
      dn = 1'b0;
      rd = 16'($urandom);
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin dn = 1'b1; rd = mem_word(saddr); end
      end else if (exp_req) begin
        lat = $urandom % 4;
        if (lat == 0) begin dn = 1'b1; rd = mem_word(m_pc); end
        else begin busy = lat; saddr = m_pc; end
      end
      drive(st, rv, rp, dn, rd);
      n_checks++; if (imem.imem_req !== exp_req || imem.imem_addr !== m_pc || err !== (exp_req && m_pc[0])) begin n_fail++; $display("FAIL rnd_bus@%0d: req %b addr %h err %b want %b %h %b", i, imem.imem_req, imem.imem_addr, err, exp_req, m_pc, exp_req && m_pc[0]); end
      if (rv) begin
        m_pc = rp; m_ifi = 16'h0800; m_ifv = 1'b0; m_halt = 1'b0; m_hp = 1'b0;
        if (m_out && !dn) m_disc = 1'b1;
        else begin m_out = 1'b0; m_disc = 1'b0; end
      end else begin
        gotv = 1'b0; got = 16'h0000;
        if (m_halt) begin
          gotv = 1'b0;
        end else if (m_hp) begin
          if (!st) begin gotv = 1'b1; got = m_pend; m_hp = 1'b0; end
        end else if (m_out) begin
          if (dn) begin
            m_out = 1'b0;
            if (m_disc) m_disc = 1'b0;
            else if (st) begin m_hp = 1'b1; m_pend = rd; end
            else begin gotv = 1'b1; got = rd; end
          end
        end else if (exp_req) begin
          if (dn) begin gotv = 1'b1; got = rd; end
          else m_out = 1'b1;
        end
        if (gotv) begin
          m_ifi = got; m_ifpc = m_pc + 16'd2; m_ifv = 1'b1; m_pc = m_pc + 16'd2;
`ifdef FETCH_PERF_CNT_EN
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
          if (got[15:11] == 5'b00000) m_halt = 1'b1;
        end
      end
      tick;
      n_checks++; if (if_instr !== m_ifi || if_pc_plus2 !== m_ifpc || if_valid !== m_ifv || halted !== m_halt || fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_ifid@%0d: %h %h %b %b %h want %h %h %b %b %h", i, if_instr, if_pc_plus2, if_valid, halted, fetch_count, m_ifi, m_ifpc, m_ifv, m_halt, m_cnt); end
    end
  endtask

  initial begin
    imem.imem_done  = 1'b0;
    imem.imem_rdata = 16'h0000;
    test_reset;
    test_back_to_back;
    test_late_hold;
    test_redirect_wait;
    test_halt;
    test_misalign_count;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
